// File: rtl/tt_capture_counter.sv
// Time-tagging counter: a PPS-restarted cycle counter with per-channel trigger capture.
// Each channel holds its tag until acknowledged and flags edges that arrive while it is held.
module tt_capture_counter #(
  parameter int               WIDTH     = 28,
  parameter int               N_CH      = 2,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  ce,
  input  logic                  pps,
  input  logic [N_CH-1:0]       trig,
  input  logic [N_CH-1:0]       ack,
  output logic [WIDTH-1:0]      count,
  output logic [WIDTH-1:0]      pps_count,
  output logic                  pps_valid,
  output logic                  rollover,
  output logic [N_CH*WIDTH-1:0] tag,
  output logic [N_CH-1:0]       tag_valid,
  output logic [N_CH-1:0]       tag_ovf
);

  logic             pps_d;
  logic [N_CH-1:0]  trig_d;
  logic             pps_edge;
  logic [N_CH-1:0]  trig_edge;
  logic [WIDTH-1:0] tag_r [N_CH];

  assign pps_edge  = pps & ~pps_d;
  assign trig_edge = trig & ~trig_d;

  // Delay registers also follow the inputs during reset, so levels already high at release are not edges.
  always_ff @(posedge clk) begin
    pps_d  <= pps;
    trig_d <= trig;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      count     <= '0;
      pps_count <= '0;
      pps_valid <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      pps_valid <= pps_edge;
      rollover  <= 1'b0;
      if (pps_edge) begin
        count     <= '0;
        pps_count <= count;
      end else if (ce) begin
        if (count == MAX_COUNT) begin
          count    <= '0;
          rollover <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // An acknowledge on the same edge as a new trigger frees the slot, so the new edge is captured.
  always_ff @(posedge clk) begin
    if (!res) begin
      for (int i = 0; i < N_CH; i++) begin
        tag_r[i] <= '0;
      end
      tag_valid <= '0;
      tag_ovf   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (trig_edge[i] && (!tag_valid[i] || ack[i])) begin
          tag_r[i]     <= count;
          tag_valid[i] <= 1'b1;
          tag_ovf[i]   <= 1'b0;
        end else if (trig_edge[i]) begin
          tag_ovf[i] <= 1'b1;
        end else if (ack[i]) begin
          tag_valid[i] <= 1'b0;
          tag_ovf[i]   <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_tag
    assign tag[g*WIDTH +: WIDTH] = tag_r[g];
  end

endmodule
